// File: rtl/instr_loader_if.sv
// Bundle of the loader's control, byte-stream and instruction-memory signals.
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  load_start;
    logic [ADDR_WIDTH:0]   load_len;
    logic                  load_abort;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [15:0]           imem_wdata;
    logic                  core_hold;
    logic                  load_done;
    logic                  load_error;
    logic [15:0]           checksum;

    // Host / stream side drives the requests and bytes.
    modport master (
        output load_start, load_len, load_abort, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, core_hold,
               load_done, load_error, checksum
    );

    modport slave (
        input  load_start, load_len, load_abort, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, core_hold,
               load_done, load_error, checksum
    );
endinterface

// File: rtl/instr_loader.sv
// Packs a byte stream (MSB first) into 16-bit instructions and writes them to
// instruction memory from address 0, holding the core off while loading.
module instr_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input logic           clock,
    input logic           reset_n,
    instr_loader_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HI    = 3'd1;
    localparam logic [2:0] LO    = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_count;
    logic [7:0]            r_hiByte;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [15:0]           r_checksum;
    logic                  r_error;

    logic                  w_inLoad;
    logic                  w_abort;
    logic                  w_lenOk;
    logic [ADDR_WIDTH:0]   w_countNext;

    assign w_inLoad    = (r_state == HI) || (r_state == LO) || (r_state == WRITE);
    assign w_abort     = w_inLoad && bus.load_abort;
    assign w_lenOk     = (bus.load_len != '0) && (bus.load_len <= MAX_LEN);
    assign w_countNext = r_count + COUNT_ONE;

    // Abort outranks any handshake or write in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_count    <= '0;
            r_hiByte   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_checksum <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.load_start) begin
                            if (w_lenOk) begin
                                r_len      <= bus.load_len;
                                r_addr     <= '0;
                                r_count    <= '0;
                                r_checksum <= '0;
                                r_state    <= HI;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    HI: begin
                        if (bus.byte_valid) begin
                            r_hiByte <= bus.byte_in;
                            r_state  <= LO;
                        end
                    end
                    LO: begin
                        if (bus.byte_valid) begin
                            r_wdata <= {r_hiByte, bus.byte_in};
                            r_state <= WRITE;
                        end
                    end
                    WRITE: begin
                        r_checksum <= r_checksum + r_wdata;
                        r_count    <= w_countNext;
                        if (w_countNext == r_len) begin
                            r_state <= DONE;
                        end else begin
                            r_addr  <= r_addr + ADDR_ONE;
                            r_state <= HI;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Handshake and hold flags decode the registered state only.
    assign bus.byte_ready = (r_state == HI) || (r_state == LO);
    assign bus.imem_we    = (r_state == WRITE) && !bus.load_abort;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.core_hold  = w_inLoad;
    assign bus.load_done  = (r_state == DONE);
    assign bus.load_error = r_error;
    assign bus.checksum   = r_checksum;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected writes are queued as stimulus is
// driven and popped by a write monitor when imem_we is seen.
module tb_instr_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;
    logic [23:0] expQ[$];
    logic [23:0] expEntry;
    int   writeCycles[$];

    instr_loader_if #(.ADDR_WIDTH(AW)) bus();

    instr_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [AW:0] len,
                                 input logic abort, input logic [7:0] data,
                                 input logic valid);
        bus.load_start = start;
        bus.load_len   = len;
        bus.load_abort = abort;
        bus.byte_in    = data;
        bus.byte_valid = valid;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that consumed the byte.
    task automatic feedByte(input logic [7:0] data);
        bit done = 1'b0;
        bus.byte_in    = data;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (bus.byte_ready === 1'b1) done = 1'b1;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL byte timeout: observed no byte_ready, expected handshake for %0h", data);
        end
    endtask

    always @(negedge clock) begin
        if (bus.imem_we === 1'b1) begin
            writeCycles.push_back(cycle);
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpected write: observed addr %0h data %0h, expected no write",
                       bus.imem_addr, bus.imem_wdata);
            end else begin
                expEntry = expQ.pop_front();
                checkOutput("wr addr", 32'(bus.imem_addr), 32'(expEntry[23:16]));
                checkOutput("wr data", 32'(bus.imem_wdata), 32'(expEntry[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        repeat (2) nextCycle();
        @(negedge clock);
        checkOutput("rst byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("rst imem_we",    32'(bus.imem_we),    32'd0);
        checkOutput("rst imem_addr",  32'(bus.imem_addr),  32'd0);
        checkOutput("rst imem_wdata", 32'(bus.imem_wdata), 32'd0);
        checkOutput("rst core_hold",  32'(bus.core_hold),  32'd0);
        checkOutput("rst load_done",  32'(bus.load_done),  32'd0);
        checkOutput("rst load_error", 32'(bus.load_error), 32'd0);
        checkOutput("rst checksum",   32'(bus.checksum),   32'd0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        // Two-word load with valid held high
        writeCycles.delete();
        expQ.push_back({8'h00, 16'h1234});
        expQ.push_back({8'h01, 16'h5678});
        applyStimulus(1'b1, 9'd2, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd2, 1'b0, 8'h00, 1'b0);
        feedByte(8'h12);
        feedByte(8'h34);
        feedByte(8'h56);
        feedByte(8'h78);
        bus.byte_valid = 1'b0;
        @(negedge clock);
        checkOutput("t2 hold in write", 32'(bus.core_hold), 32'd1);
        nextCycle();
        @(negedge clock);
        checkOutput("t2 load_done",    32'(bus.load_done), 32'd1);
        checkOutput("t2 hold released", 32'(bus.core_hold), 32'd0);
        checkOutput("t2 checksum",     32'(bus.checksum),  32'h68AC);
        checkOutput("t2 last addr",    32'(bus.imem_addr), 32'd1);
        checkOutput("t2 write count",  32'(writeCycles.size()), 32'd2);
        if (writeCycles.size() == 2) begin
            checkOutput("t2 write spacing", 32'(writeCycles[1] - writeCycles[0]), 32'd3);
            checkOutput("t2 done latency",  32'(cycle - writeCycles[1]), 32'd1);
        end
        nextCycle();
        @(negedge clock);
        checkOutput("t2 done pulse end", 32'(bus.load_done), 32'd0);
        checkOutput("t2 idle ready",     32'(bus.byte_ready), 32'd0);

        // Rejected lengths
        applyStimulus(1'b1, 9'd0, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("len0 error",  32'(bus.load_error), 32'd1);
        checkOutput("len0 hold",   32'(bus.core_hold),  32'd0);
        checkOutput("len0 ready",  32'(bus.byte_ready), 32'd0);
        nextCycle();
        @(negedge clock);
        checkOutput("len0 error end", 32'(bus.load_error), 32'd0);
        applyStimulus(1'b1, 9'(DEPTH + 1), 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("lenmax error",    32'(bus.load_error), 32'd1);
        checkOutput("lenmax hold",     32'(bus.core_hold),  32'd0);
        checkOutput("lenmax checksum", 32'(bus.checksum),   32'h68AC);
        nextCycle();

        // Checksum cleared by each new load
        expQ.push_back({8'h00, 16'hFFFF});
        applyStimulus(1'b1, 9'd1, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd1, 1'b0, 8'h00, 1'b0);
        feedByte(8'hFF);
        feedByte(8'hFF);
        bus.byte_valid = 1'b0;
        nextCycle();
        @(negedge clock);
        checkOutput("t4a checksum", 32'(bus.checksum),  32'hFFFF);
        checkOutput("t4a done",     32'(bus.load_done), 32'd1);
        nextCycle();
        expQ.push_back({8'h00, 16'h0001});
        applyStimulus(1'b1, 9'd1, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd1, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("t4b cleared", 32'(bus.checksum), 32'd0);
        nextCycle();
        feedByte(8'h00);
        feedByte(8'h01);
        bus.byte_valid = 1'b0;
        nextCycle();
        @(negedge clock);
        checkOutput("t4b checksum", 32'(bus.checksum),  32'h0001);
        checkOutput("t4b done",     32'(bus.load_done), 32'd1);
        nextCycle();

        // Stall in LO
        expQ.push_back({8'h00, 16'hABCD});
        applyStimulus(1'b1, 9'd1, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd1, 1'b0, 8'h00, 1'b0);
        feedByte(8'hAB);
        bus.byte_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("stall ready", 32'(bus.byte_ready), 32'd1);
            checkOutput("stall we",    32'(bus.imem_we),    32'd0);
            checkOutput("stall hold",  32'(bus.core_hold),  32'd1);
            nextCycle();
        end
        feedByte(8'hCD);
        bus.byte_valid = 1'b0;
        @(negedge clock);
        checkOutput("stall write next", 32'(bus.imem_we), 32'd1);
        nextCycle();
        @(negedge clock);
        checkOutput("stall checksum", 32'(bus.checksum),  32'hABCD);
        checkOutput("stall done",     32'(bus.load_done), 32'd1);
        nextCycle();

        // Abort coinciding with the LO handshake
        expQ.push_back({8'h00, 16'h3344});
        applyStimulus(1'b1, 9'd2, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd2, 1'b0, 8'h00, 1'b0);
        feedByte(8'h11);
        applyStimulus(1'b0, 9'd2, 1'b1, 8'h22, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 9'd2, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("abort error", 32'(bus.load_error), 32'd1);
        checkOutput("abort hold",  32'(bus.core_hold),  32'd0);
        checkOutput("abort ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("abort we",    32'(bus.imem_we),    32'd0);
        applyStimulus(1'b1, 9'd1, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd1, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("restart hold",  32'(bus.core_hold),  32'd1);
        checkOutput("restart ready", 32'(bus.byte_ready), 32'd1);
        nextCycle();
        feedByte(8'h33);
        feedByte(8'h44);
        bus.byte_valid = 1'b0;
        nextCycle();
        @(negedge clock);
        checkOutput("restart checksum", 32'(bus.checksum),  32'h3344);
        checkOutput("restart done",     32'(bus.load_done), 32'd1);
        nextCycle();

        // Reset while in LO
        applyStimulus(1'b1, 9'd2, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 9'd2, 1'b0, 8'h00, 1'b0);
        feedByte(8'h55);
        bus.byte_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("midrst imem_we",    32'(bus.imem_we),    32'd0);
        checkOutput("midrst imem_addr",  32'(bus.imem_addr),  32'd0);
        checkOutput("midrst imem_wdata", 32'(bus.imem_wdata), 32'd0);
        checkOutput("midrst core_hold",  32'(bus.core_hold),  32'd0);
        checkOutput("midrst load_done",  32'(bus.load_done),  32'd0);
        checkOutput("midrst load_error", 32'(bus.load_error), 32'd0);
        checkOutput("midrst checksum",   32'(bus.checksum),   32'd0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        @(negedge clock);
        checkOutput("postrst ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("postrst hold",  32'(bus.core_hold),  32'd0);
        repeat (3) nextCycle();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
